// File: rtl/sr_latch_driver_if.sv
// Command handshake and active-low latch strobes between an upstream
// controller and sr_latch_driver.
interface sr_latch_driver_if;
  logic cmd_valid;
  logic cmd_set;
  logic cmd_ready;
  logic s;
  logic r;
  logic busy;
  logic done;
  logic q_shadow;

  modport master (
    output cmd_valid, cmd_set,
    input  cmd_ready, s, r, busy, done, q_shadow
  );

  modport slave (
    input  cmd_valid, cmd_set,
    output cmd_ready, s, r, busy, done, q_shadow
  );
endinterface

// File: rtl/sr_latch_driver.sv
// Turns set/clear commands into clean active-low s/r pulses of PULSE_W cycles,
// each followed by a GAP_W-cycle guard gap, and tracks the expected latch state.
module sr_latch_driver #(
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 2,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  sr_latch_driver_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE_S = 2'd1,
    PULSE_R = 2'd2,
    GAP     = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               s_q, s_d;
  logic               r_q, r_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               q_shadow_q, q_shadow_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    q_shadow_d = q_shadow_q;

    case (state_q)
      IDLE: begin
        // ready_q gates acceptance so the first cycle after reset ignores commands
        if (bus.cmd_valid && ready_q) begin
          cnt_d   = CNT_W'(PULSE_W - 1);
          state_d = bus.cmd_set ? PULSE_S : PULSE_R;
        end
      end
      PULSE_S, PULSE_R: begin
        if (cnt_q == '0) begin
          q_shadow_d = (state_q == PULSE_S);
          cnt_d      = CNT_W'(GAP_W - 1);
          state_d    = GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs decode the next state, so s and r can only ever be low in
    // mutually exclusive states and are glitch-free registers.
    s_d     = (state_d != PULSE_S);
    r_d     = (state_d != PULSE_R);
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
    done_d  = (state_d == GAP) && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      s_q        <= 1'b1;
      r_q        <= 1'b1;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      q_shadow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s_q        <= s_d;
      r_q        <= r_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      q_shadow_q <= q_shadow_d;
    end
  end

  assign bus.s         = s_q;
  assign bus.r         = r_q;
  assign bus.cmd_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.q_shadow  = q_shadow_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: a default-width instance driven by directed
// sequences and a minimum-width instance driven by random commands.
module tb_sr_latch_driver;

  localparam int PW_A = 4;
  localparam int GW_A = 2;
  localparam int PW_B = 1;
  localparam int GW_B = 1;

  logic clk;
  logic rst_a;
  logic rst_b;

  int checks = 0;
  int errors = 0;

  sr_latch_driver_if bus_a();
  sr_latch_driver_if bus_b();

  sr_latch_driver #(.PULSE_W(PW_A), .GAP_W(GW_A), .CNT_W(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_a),
    .bus   (bus_a)
  );

  sr_latch_driver #(.PULSE_W(PW_B), .GAP_W(GW_B), .CNT_W(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_b),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timeline model: k counts cycles since the accept edge (0 = no command).
  // Cycles 1..PW are the pulse, PW+1..PW+GW the gap, done on the last gap cycle.
  int   mk   [2] = '{0, 0};
  bit   mset [2] = '{0, 0};
  bit   mq   [2] = '{0, 0};
  bit   mblk [2] = '{1, 1};
  bit   mon  [2] = '{0, 0};
  int   acc  [2] = '{0, 0};

  logic [1:0] rstv, valv, setv;
  assign rstv = {rst_b, rst_a};
  assign valv = {bus_b.cmd_valid, bus_a.cmd_valid};
  assign setv = {bus_b.cmd_set, bus_a.cmd_set};

  logic [5:0] act [2];
  assign act[0] = {bus_a.cmd_ready, bus_a.s, bus_a.r, bus_a.busy, bus_a.done, bus_a.q_shadow};
  assign act[1] = {bus_b.cmd_ready, bus_b.s, bus_b.r, bus_b.busy, bus_b.done, bus_b.q_shadow};

  function automatic int pw_of(input int i);
    return (i == 0) ? PW_A : PW_B;
  endfunction

  function automatic int gw_of(input int i);
    return (i == 0) ? GW_A : GW_B;
  endfunction

  function automatic logic [5:0] model_out(input int k, input bit st, input bit q,
                                           input bit blk, input int p, input int g);
    bit pul;
    pul = (k >= 1) && (k <= p);
    return {(k == 0) && !blk, !(pul && st), !(pul && !st), k != 0, k == p + g, q};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rstv[i]) begin
        mk[i]   <= 0;
        mq[i]   <= 1'b0;
        mblk[i] <= 1'b1;
        mon[i]  <= 1'b1;
      end else begin
        mblk[i] <= 1'b0;
        if (mk[i] == 0) begin
          if (!mblk[i] && valv[i]) begin
            mk[i]   <= 1;
            mset[i] <= setv[i];
            acc[i]  <= acc[i] + 1;
          end
        end else if (mk[i] == pw_of(i) + gw_of(i)) begin
          mk[i] <= 0;
        end else begin
          mk[i] <= mk[i] + 1;
          if (mk[i] == pw_of(i)) mq[i] <= mset[i];
        end
      end
    end
  end

  // Latch fed by dut_b's strobes; q_shadow must agree whenever no strobe is active.
  bit latch_b = 1'b0;
  int lowcnt_b = 0;

  always @(negedge clk) begin
    logic [5:0] e;
    for (int i = 0; i < 2; i++) begin
      if (mon[i]) begin
        e = model_out(mk[i], mset[i], mq[i], mblk[i], pw_of(i), gw_of(i));
        checks++;
        if (act[i] !== e) begin
          errors++;
          $display("FAIL model_dut%0d t=%0t {ready,s,r,busy,done,q} actual=%b expected=%b",
                   i, $time, act[i], e);
        end
        checks++;
        if (act[i][4:3] == 2'b00) begin
          errors++;
          $display("FAIL both_low_dut%0d t=%0t s,r actual=%b expected not 00", i, $time, act[i][4:3]);
        end
      end
    end
    if (!rst_b) begin
      latch_b = 1'b0;
    end else if (mon[1]) begin
      if (!bus_b.s || !bus_b.r) lowcnt_b++;
      if (!bus_b.s) latch_b = 1'b1;
      else if (!bus_b.r) latch_b = 1'b0;
      if (bus_b.s && bus_b.r) begin
        checks++;
        if (bus_b.q_shadow !== latch_b) begin
          errors++;
          $display("FAIL latch_vs_shadow t=%0t q_shadow actual=%b latch expected=%b",
                   $time, bus_b.q_shadow, latch_b);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string nm, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", nm, a, e);
    end
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, a, e);
    end
  endtask

  task automatic run_a();
    logic [6:0] es, eq, ed, er;
    int cs, cr;
    es = 7'b1110000;
    eq = 7'b1110000;
    ed = 7'b0100000;
    er = 7'b1000000;
    rst_a = 1'b0;
    bus_a.cmd_valid = 1'b0;
    bus_a.cmd_set   = 1'b0;

    repeat (3) begin
      step();
      lit("rst_s", bus_a.s, 1'b1);
      lit("rst_r", bus_a.r, 1'b1);
      lit("rst_q", bus_a.q_shadow, 1'b0);
      lit("rst_busy", bus_a.busy, 1'b0);
      lit("rst_ready", bus_a.cmd_ready, 1'b0);
    end
    rst_a = 1'b1;
    step();
    lit("post_rst_ready", bus_a.cmd_ready, 1'b1);
    $display("T1 reset and idle");

    bus_a.cmd_valid = 1'b1;
    bus_a.cmd_set   = 1'b1;
    step();
    bus_a.cmd_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      lit("t2_s", bus_a.s, es[k-1]);
      lit("t2_r", bus_a.r, 1'b1);
      lit("t2_q", bus_a.q_shadow, eq[k-1]);
      lit("t2_done", bus_a.done, ed[k-1]);
      lit("t2_ready", bus_a.cmd_ready, er[k-1]);
      if (k < 7) step();
    end
    $display("T2 single set command");

    bus_a.cmd_valid = 1'b1;
    bus_a.cmd_set   = 1'b1;
    step();
    bus_a.cmd_set = 1'b0;
    repeat (6) step();
    lit("t3_ready1", bus_a.cmd_ready, 1'b1);
    step();
    bus_a.cmd_valid = 1'b0;
    lit("t3_r_low", bus_a.r, 1'b0);
    lit("t3_s_high", bus_a.s, 1'b1);
    lit("t3_q_mid", bus_a.q_shadow, 1'b1);
    repeat (6) step();
    lit("t3_q_end", bus_a.q_shadow, 1'b0);
    lit("t3_ready2", bus_a.cmd_ready, 1'b1);
    $display("T3 back-to-back set then clear");

    bus_a.cmd_valid = 1'b1;
    bus_a.cmd_set   = 1'b1;
    step();
    cs = 0;
    cr = 0;
    for (int k = 1; k <= 6; k++) begin
      if (!bus_a.s) cs++;
      if (!bus_a.r) cr++;
      bus_a.cmd_valid = (k < 5) ? k[0] : 1'b0;
      bus_a.cmd_set   = ~bus_a.cmd_set;
      step();
    end
    chk_int("t4_s_low_cycles", cs, 4);
    chk_int("t4_r_low_cycles", cr, 0);
    lit("t4_ready", bus_a.cmd_ready, 1'b1);
    lit("t4_q", bus_a.q_shadow, 1'b1);
    $display("T4 commands while busy ignored");

    bus_a.cmd_valid = 1'b1;
    bus_a.cmd_set   = 1'b0;
    step();
    bus_a.cmd_valid = 1'b0;
    lit("t5_r_c1", bus_a.r, 1'b0);
    step();
    lit("t5_r_c2", bus_a.r, 1'b0);
    rst_a = 1'b0;
    step();
    lit("t5_s", bus_a.s, 1'b1);
    lit("t5_r", bus_a.r, 1'b1);
    lit("t5_busy", bus_a.busy, 1'b0);
    lit("t5_q", bus_a.q_shadow, 1'b0);
    lit("t5_done", bus_a.done, 1'b0);
    rst_a = 1'b1;
    step();
    lit("t5_ready", bus_a.cmd_ready, 1'b1);
    repeat (4) step();
    $display("T5 reset mid-pulse");
  endtask

  task automatic run_b();
    int cyc;
    rst_b = 1'b0;
    bus_b.cmd_valid = 1'b0;
    bus_b.cmd_set   = 1'b0;
    repeat (3) step();
    rst_b = 1'b1;
    step();
    lit("b_post_rst_ready", bus_b.cmd_ready, 1'b1);
    cyc = 0;
    while (acc[1] < 1000 && cyc < 20000) begin
      bus_b.cmd_valid = 1'($urandom_range(0, 1));
      bus_b.cmd_set   = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    bus_b.cmd_valid = 1'b0;
    repeat (5) step();
    chk_int("b_accepted_commands", acc[1], 1000);
    chk_int("b_low_cycles_vs_accepts", lowcnt_b, acc[1]);
    $display("T6 min widths: %0d commands in %0d cycles", acc[1], cyc);
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_a.cmd_valid = 1'b0;
    bus_a.cmd_set   = 1'b0;
    bus_b.cmd_valid = 1'b0;
    bus_b.cmd_set   = 1'b0;
    fork
      run_a();
      run_b();
    join
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
